fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain control stage of the asynchronous FIFO. It sits directly upstream of the `fifomem` storage array and drives that array's write address and `full` input. It also owns the binary and Gray write pointers and synchronizes the read-domain Gray pointer into the write clock. From these it produces registered `full`, `almost_full` and a conservative fill level.

## Interface
Parameters:
- `add_size`, 4: memory address bits; DEPTH = 2^add_size; pointers are add_size+1 bits; legal range ≥ 2.
- `afull_margin`, 2: `almost_full` asserts when level ≥ DEPTH − afull_margin; legal range 1..DEPTH−1.

Ports:
- `wr_clk`, in, 1: write-domain clock; the only clock in this block.
- `wr_rst`, in, 1: reset; asynchronous, active-high.
- `wr_inc`, in, 1: write request; the same signal drives `fifomem` `wr_clken`.
- `rd_gray_ptr`, in, add_size+1: read pointer in Gray code from the read domain; asynchronous to `wr_clk`.
- `wr_addr`, out, add_size: memory write address (low bits of the binary write pointer).
- `wr_gray_ptr`, out, add_size+1: registered Gray write pointer, exported to the read domain.
- `full`, out, 1: FIFO full; drives `fifomem` `full`.
- `almost_full`, out, 1: level ≥ DEPTH − afull_margin.
- `wr_level`, out, add_size+1: entries occupied as seen from the write domain; range 0..DEPTH.

## Operation
- Accepted write = `wr_inc && !full`. Any `wr_inc` while `full` is ignored: no pointer change and no error flag.
- Internal state:
  - `wbin`: binary write pointer, add_size+1 bits.
  - `wgray`: registered Gray write pointer.
  - `rq1`, `rq2`: two-flop synchronizer stages for `rd_gray_ptr`.
- Next-state values:
  - `wbin_next` = `wbin` + accepted, modulo 2^(add_size+1); it wraps naturally.
  - `wgray_next` = `wbin_next` ^ (`wbin_next` >> 1).
- Full rule: `full_next` = (`wgray_next` == {~`rq2`[MSB:MSB−1], `rq2`[MSB−2:0]}). That is, the top two bits are inverted and the rest are equal.
- Level rule: `wr_level_next` = `wbin_next` − gray2bin(`rq2`), modulo 2^(add_size+1). The result never exceeds DEPTH.
- `almost_full_next` = (`wr_level_next` ≥ DEPTH − afull_margin).
- All outputs come directly from flops; there is no combinational path from input to output.
- The read pointer seen through `rq2` is always stale, so `full` and `wr_level` are pessimistic. Overflow is never possible; `full` may be released late.

## Timing
- Reset: `wbin`, `wgray`, `rq1`, `rq2`, `wr_addr`, `wr_gray_ptr`, `wr_level`, `full` and `almost_full` all go to 0.
  - Values clear immediately on `wr_rst` assertion, including mid-operation; no partial increment survives.
  - The first write is accepted on the first `wr_clk` edge after `wr_rst` deasserts.
- Write pointer latency: an accepted write at edge N updates `wr_addr` and `wr_gray_ptr` at edge N. `fifomem` samples the old address at that same edge.
- Full set: `full` rises on the same edge that accepts the DEPTH-th outstanding write. A `wr_inc` on the next cycle is blocked.
- Full release: a `rd_gray_ptr` change reaches `rq2` after 2 `wr_clk` edges. `full`, `level` and `almost_full` update on that same edge, so `full` clears 2–3 `wr_clk` cycles after the read pointer advances.
- Simultaneous write and read-pointer advance while not full: the level stays constant once the synchronizer catches up.
- Wrap-around: after 2·DEPTH accepted writes the pointer MSB has toggled twice. `wbin` returns to 0, and `full` is evaluated correctly across every wrap.
- `wr_gray_ptr` changes by exactly one bit per accepted write. This is required for safe crossing into the read domain.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterized by width.
  - The common pointer-width constant rule (add_size+1).
- One sub-module, `sync_r2w`: a two-flop synchronizer for `rd_gray_ptr`, add_size+1 bits wide, async active-high reset to 0.
  - The read-domain mirror block reuses the same design.
- No other hierarchy. All flops are in the `wr_clk` domain.

## Test plan
Default parameters for every test: add_size=4 (DEPTH=16), afull_margin=2.
- Reset: assert `wr_rst` mid-stream with `wbin`=7. All outputs read 0 immediately; the first `wr_inc` after release gives `wr_addr`=1.
- Fill: `rd_gray_ptr`=0 and 16 consecutive `wr_inc` pulses. `almost_full` rises after write 14 (level 14), `full` rises after write 16 (level 16), and a 17th `wr_inc` leaves `wr_addr`=0 and `wr_gray_ptr`=5'b11000.
- Release: from full, set `rd_gray_ptr` to gray(1)=5'b00001. `full` clears exactly 2 edges later and `wr_level`=15.
- Wrap: interleave writes with read-pointer updates through 40 writes. `wbin` wraps at 32, `full` never asserts while level < 16, and `wr_gray_ptr` shows exactly one bit flip per write.
- Gray check: after each accepted write, verify `wr_gray_ptr` == bin2gray(write count mod 32).
- Full behaviour vs. stale read pointer: the read pointer advances by 3 and `wr_inc` is held high. No write is accepted until `rq2` reflects the change, after which exactly 3 writes are accepted.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic.
// Gray/binary conversion and the pointer width rule.
package fifo_pkg;

  // Pointers carry one extra bit to tell full from empty.
  function automatic int ptr_width(input int add_size);
    return add_size + 1;
  endfunction

  // Both helpers work on zero-extended values, so they serve
  // any pointer width up to 32 bits; callers truncate back.
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer for a Gray pointer.
// Ports: i_clk, i_rst (async high), i_d -> o_q (stage 2), o_q_next (stage 1).
module sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q      = r_q2;
  assign o_q_next = r_q1;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and fill level.
// Ports: wr_clk, wr_rst, wr_inc, rd_gray_ptr in; wr_addr, wr_gray_ptr, full, almost_full, wr_level out.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int add_size     = 4,
  parameter int afull_margin = 2
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_inc,
  input  logic [add_size:0] rd_gray_ptr,
  output logic [add_size-1:0] wr_addr,
  output logic [add_size:0] wr_gray_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [add_size:0] wr_level
);

  localparam int PW    = ptr_width(add_size);
  localparam int DEPTH = 1 << add_size;
  localparam logic [PW-1:0] AFULL_TH =
    PW'(DEPTH - afull_margin);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_afull;

  logic [PW-1:0] w_rq2;
  logic [PW-1:0] w_rq2_next;
  logic          w_accept;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;
  logic          w_afull_next;
  logic          w_unused_rq2;

  sync_r2w #(
    .WIDTH(PW)
  ) u_sync (
    .i_clk   (wr_clk),
    .i_rst   (wr_rst),
    .i_d     (rd_gray_ptr),
    .o_q     (w_rq2),
    .o_q_next(w_rq2_next)
  );

  // Stage 2 itself feeds nothing here; the status flops
  // below load from the value stage 2 takes on this edge.
  assign w_unused_rq2 = ^w_rq2;

  assign w_accept    = wr_inc & ~r_full;
  assign w_wbin_next = r_wbin + PW'(w_accept);
  assign w_wgray_next =
    PW'(bin2gray(32'(w_wbin_next)));

  // Status is judged against the read pointer stage 2 is
  // loading now, so it moves on the same edge as rq2.
  assign w_rbin_next =
    PW'(gray2bin(32'(w_rq2_next)));
  assign w_level_next = w_wbin_next - w_rbin_next;

  // Full: Gray pointers differ only in the top two bits.
  assign w_full_next = (w_wgray_next ==
    {~w_rq2_next[PW-1:PW-2], w_rq2_next[PW-3:0]});
  assign w_afull_next = (w_level_next >= AFULL_TH);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
    end
  end

  assign wr_addr     = r_wbin[add_size-1:0];
  assign wr_gray_ptr = r_wgray;
  assign wr_level    = r_level;
  assign full        = r_full;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: count-based model of
// writes, lagged read count and derived status.
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          wr_inc;
  logic [AW:0]   rd_gray_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;

  fifo_wptr_full #(
    .add_size    (AW),
    .afull_margin(2)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst     (wr_rst),
    .wr_inc     (wr_inc),
    .rd_gray_ptr(rd_gray_ptr),
    .wr_addr    (wr_addr),
    .wr_gray_ptr(wr_gray_ptr),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level)
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  int rcount;
  int m_w, m_level, rd_prev;
  bit m_full, m_afull;
  logic [AW:0] prev_g;

  function automatic int g(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic set_rd(input int n);
    rcount = n;
    rd_gray_ptr = (AW+1)'(g(n % 32));
  endtask

  // Model: total writes, and the read count as seen
  // through two write-clock edges of synchronization.
  always @(posedge wr_clk or posedge wr_rst) begin
    int nw;
    if (wr_rst) begin
      m_w     <= 0;
      m_level <= 0;
      m_full  <= 0;
      m_afull <= 0;
      rd_prev <= 0;
    end else begin
      nw = m_w + ((wr_inc && !m_full) ? 1 : 0);
      m_w     <= nw;
      m_level <= nw - rd_prev;
      m_full  <= (nw - rd_prev) == DEPTH;
      m_afull <= (nw - rd_prev) >= DEPTH - 2;
      rd_prev <= rcount;
    end
  end

  always @(negedge wr_clk) begin
    if (wr_rst) begin
      prev_g = '0;
    end else if (chk_en) begin
      chk("addr", wr_addr, m_w % DEPTH);
      chk("gray", wr_gray_ptr, g(m_w % 32));
      chk("full", full, m_full);
      chk("afull", almost_full, m_afull);
      chk("level", wr_level, m_level);
      if (wr_gray_ptr != prev_g)
        chk("gray_1bit",
            $countones(wr_gray_ptr ^ prev_g), 1);
      prev_g = wr_gray_ptr;
    end
  end

  initial begin
    wr_rst = 1;
    wr_inc = 0;
    set_rd(0);
    repeat (2) tick();
    wr_rst = 0;
    chk_en = 1;

    // reset mid-stream at wbin=7
    wr_inc = 1;
    repeat (7) tick();
    wr_inc = 0;
    chk("pre_rst_addr", wr_addr, 7);
    wr_rst = 1;
    #1;
    chk("rst_addr", wr_addr, 0);
    chk("rst_gray", wr_gray_ptr, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_level", wr_level, 0);
    tick();
    wr_rst = 0;
    wr_inc = 1;
    tick();
    wr_inc = 0;
    chk("first_addr", wr_addr, 1);

    // fill from empty
    wr_rst = 1;
    tick();
    wr_rst = 0;
    wr_inc = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 13) chk("afull_13", almost_full, 0);
      if (i == 14) begin
        chk("afull_14", almost_full, 1);
        chk("level_14", wr_level, 14);
      end
      if (i == 15) chk("full_15", full, 0);
      if (i == 16) begin
        chk("full_16", full, 1);
        chk("level_16", wr_level, 16);
      end
    end
    tick();
    chk("blk_addr", wr_addr, 0);
    chk("blk_gray", wr_gray_ptr, 24);
    chk("blk_full", full, 1);

    // release by one read
    wr_inc = 0;
    set_rd(1);
    tick();
    chk("rel_e1_full", full, 1);
    tick();
    chk("rel_e2_full", full, 0);
    chk("rel_e2_level", wr_level, 15);

    // refill, then stale read pointer advance by 3
    wr_inc = 1;
    tick();
    chk("refull", full, 1);
    chk("refull_addr", wr_addr, 1);
    set_rd(4);
    tick();
    chk("st_e1_addr", wr_addr, 1);
    chk("st_e1_full", full, 1);
    tick();
    chk("st_e2_addr", wr_addr, 1);
    chk("st_e2_full", full, 0);
    chk("st_e2_level", wr_level, 13);
    tick();
    chk("st_e3_addr", wr_addr, 2);
    repeat (2) tick();
    chk("st_e5_addr", wr_addr, 4);
    chk("st_e5_full", full, 1);
    repeat (2) tick();
    chk("st_e7_addr", wr_addr, 4);

    // random traffic: slow reads then fast reads
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 200; c++) begin
        wr_inc = ($urandom_range(0, 3) != 0);
        if (rcount < m_w &&
            $urandom_range(0, (ph == 1) ? 0 : 2) == 0)
          set_rd(rcount + 1);
        tick();
      end
    end
    wr_inc = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
